branch_predict_buffer: RTL and testbench

//  Direct-mapped branch target buffer with 2-bit saturating counters. Fetch side predicts

---
 rtl/branch_predict_buffer.sv | 155 +++++++++++++++
 tb/tb_branch_predict_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_buffer.sv
// ============================================================================
// Module  : branch_predict_buffer
// Brief   : Direct-mapped BTB with 2-bit saturating counters, branch resolve
//           and performance counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_buffer #(
  parameter int ENTRIES = 4,
  parameter int CNTW    = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [31:0]     fetch_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  input  logic            mem_valid,
  input  logic            mem_en,
  input  logic [31:0]     mem_pc,
  input  logic            mem_branch,
  input  logic            mem_taken,
  input  logic [31:0]     mem_target,
  input  logic            mem_pred_taken,
  input  logic [31:0]     mem_pred_target,
  output logic            btb_correct,
  output logic            btb_wrongtype,
  output logic [31:0]     fix_pc,
  output logic [CNTW-1:0] perf_branches,
  output logic [CNTW-1:0] perf_mispredict
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [TAGW-1:0]    tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [1:0]         cnt_d    [ENTRIES];
  logic [CNTW-1:0]    br_cnt_q, br_cnt_d;
  logic [CNTW-1:0]    mis_cnt_q, mis_cnt_d;

  logic [IDXW-1:0] w_fidx;
  logic [TAGW-1:0] w_ftag;
  logic            w_fhit;
  logic [IDXW-1:0] w_midx;
  logic [TAGW-1:0] w_mtag;
  logic            w_mhit;
  logic            w_train;

  assign w_fidx  = fetch_pc[IDXW+1:2];
  assign w_ftag  = fetch_pc[31:IDXW+2];
  assign w_fhit  = valid_q[w_fidx] && (tag_q[w_fidx] == w_ftag);
  assign w_midx  = mem_pc[IDXW+1:2];
  assign w_mtag  = mem_pc[31:IDXW+2];
  assign w_mhit  = valid_q[w_midx] && (tag_q[w_midx] == w_mtag);
  assign w_train = mem_valid && mem_en;

  // Fetch-side prediction reads pre-edge contents only; no bypass from train.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = fetch_pc + 32'd4;
    if (w_fhit && cnt_q[w_fidx][1]) begin
      pred_taken  = 1'b1;
      pred_target = target_q[w_fidx];
    end
  end

  always_comb begin
    btb_correct   = 1'b1;
    btb_wrongtype = 1'b0;
    fix_pc        = mem_pc + 32'd4;
    if (mem_valid) begin
      if (!mem_branch && mem_pred_taken) begin
        btb_correct   = 1'b0;
        btb_wrongtype = 1'b1;
      end else if (mem_branch &&
                   ((mem_pred_taken != mem_taken) ||
                    (mem_taken && (mem_pred_target != mem_target)))) begin
        btb_correct = 1'b0;
        if (mem_taken) begin
          fix_pc = mem_target;
        end
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (w_train) begin
      if (mem_branch) begin
        if (w_mhit) begin
          if (mem_taken) begin
            target_d[w_midx] = mem_target;
            if (cnt_q[w_midx] != 2'b11) begin
              cnt_d[w_midx] = cnt_q[w_midx] + 2'd1;
            end
          end else if (cnt_q[w_midx] != 2'b00) begin
            cnt_d[w_midx] = cnt_q[w_midx] - 2'd1;
          end
        end else if (mem_taken) begin
          valid_d[w_midx]  = 1'b1;
          tag_d[w_midx]    = w_mtag;
          target_d[w_midx] = mem_target;
          cnt_d[w_midx]    = 2'b10;
        end
        if (br_cnt_q != {CNTW{1'b1}}) begin
          br_cnt_d = br_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
      end else if (w_mhit) begin
        // A non-branch hitting the BTB is an alias; drop the entry.
        valid_d[w_midx] = 1'b0;
      end
      if (!btb_correct && (mis_cnt_q != {CNTW{1'b1}})) begin
        mis_cnt_d = mis_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q   <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else begin
      valid_q   <= valid_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign perf_branches   = br_cnt_q;
  assign perf_mispredict = mis_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_buffer.sv
// ============================================================================
// Module  : tb_branch_predict_buffer
// Brief   : Scoreboard bench for branch_predict_buffer against a table model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predict_buffer;

  localparam int ENTRIES = 4;
  localparam int IDXW    = 2;
  localparam int CNTW    = 16;
  localparam int CMAX    = (1 << CNTW) - 1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [31:0]     fetch_pc = '0;
  logic            pred_taken;
  logic [31:0]     pred_target;
  logic            mem_valid = 1'b0;
  logic            mem_en = 1'b0;
  logic [31:0]     mem_pc = '0;
  logic            mem_branch = 1'b0;
  logic            mem_taken = 1'b0;
  logic [31:0]     mem_target = '0;
  logic            mem_pred_taken = 1'b0;
  logic [31:0]     mem_pred_target = '0;
  logic            btb_correct;
  logic            btb_wrongtype;
  logic [31:0]     fix_pc;
  logic [CNTW-1:0] perf_branches;
  logic [CNTW-1:0] perf_mispredict;

  branch_predict_buffer #(.ENTRIES(ENTRIES), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .mem_valid(mem_valid), .mem_en(mem_en), .mem_pc(mem_pc),
    .mem_branch(mem_branch), .mem_taken(mem_taken), .mem_target(mem_target),
    .mem_pred_taken(mem_pred_taken), .mem_pred_target(mem_pred_target),
    .btb_correct(btb_correct), .btb_wrongtype(btb_wrongtype), .fix_pc(fix_pc),
    .perf_branches(perf_branches), .perf_mispredict(perf_mispredict)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    int          cnt;
  } ent_t;

  typedef struct {
    bit          ptk;
    logic [31:0] ptgt;
    bit          correct;
    bit          wrongtype;
    logic [31:0] fix;
    int          nbr;
    int          nmis;
  } exp_t;

  ent_t tbl [ENTRIES];
  int   m_br;
  int   m_mis;
  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = '{v: 1'b0, tag: 0, tgt: '0, cnt: 1};
    m_br  = 0;
    m_mis = 0;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int i = int'((pc >> 2) % ENTRIES);
    return tbl[i].v && (tbl[i].tag == int'(pc >> (IDXW + 2)));
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i = int'((pc >> 2) % ENTRIES);
    t  = model_hit(pc) && (tbl[i].cnt >= 2);
    tg = t ? tbl[i].tgt : pc + 32'd4;
  endfunction

  // One cycle: drive at posedge+1, record expectations from the model's
  // current state, then advance the model to its post-edge state.
  task automatic step(input logic [31:0] fpc, input bit v, input bit en,
                      input logic [31:0] mpc, input bit br, input bit tk,
                      input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    exp_t e;
    int   i;
    fetch_pc = fpc; mem_valid = v; mem_en = en; mem_pc = mpc;
    mem_branch = br; mem_taken = tk; mem_target = tgt;
    mem_pred_taken = ptk; mem_pred_target = ptgt;
    if (RST) model_reset();
    model_predict(fpc, e.ptk, e.ptgt);
    e.correct = 1'b1; e.wrongtype = 1'b0; e.fix = mpc + 32'd4;
    if (v && !br && ptk) begin
      e.correct = 1'b0; e.wrongtype = 1'b1;
    end else if (v && br && ((ptk != tk) || (tk && ptgt != tgt))) begin
      e.correct = 1'b0;
      e.fix = tk ? tgt : mpc + 32'd4;
    end
    e.nbr = m_br; e.nmis = m_mis;
    sb.push_back(e);
    if (!RST && v && en) begin
      i = int'((mpc >> 2) % ENTRIES);
      if (br) begin
        if (model_hit(mpc)) begin
          tbl[i].cnt = tk ? ((tbl[i].cnt < 3) ? tbl[i].cnt + 1 : 3)
                          : ((tbl[i].cnt > 0) ? tbl[i].cnt - 1 : 0);
          if (tk) tbl[i].tgt = tgt;
        end else if (tk) begin
          tbl[i] = '{v: 1'b1, tag: int'(mpc >> (IDXW + 2)), tgt: tgt, cnt: 2};
        end
        m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
      end else if (model_hit(mpc)) begin
        tbl[i].v = 1'b0;
      end
      if (!e.correct) m_mis = (m_mis < CMAX) ? m_mis + 1 : CMAX;
    end
    @(posedge CLK);
    #1;
  endtask

  // Resolve a branch carrying the model's own prediction, as the pipe would.
  task automatic resolve(input logic [31:0] fpc, input logic [31:0] mpc, input bit tk, input logic [31:0] tgt);
    bit          p;
    logic [31:0] pt;
    model_predict(mpc, p, pt);
    step(fpc, 1, 1, mpc, 1, tk, tgt, p, pt);
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pred_taken",      {31'd0, pred_taken},       {31'd0, e.ptk});
      chk("pred_target",     pred_target,               e.ptgt);
      chk("btb_correct",     {31'd0, btb_correct},      {31'd0, e.correct});
      chk("btb_wrongtype",   {31'd0, btb_wrongtype},    {31'd0, e.wrongtype});
      chk("fix_pc",          fix_pc,                    e.fix);
      chk("perf_branches",   {16'd0, perf_branches},    e.nbr[31:0]);
      chk("perf_mispredict", {16'd0, perf_mispredict},  e.nmis[31:0]);
    end
  end

  initial begin
    logic [31:0] pc, fpc, tgt;
    bit          p;
    logic [31:0] pt;

    model_reset();
    @(posedge CLK); #1;
    step(32'h40, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    RST = 1'b0;

    // Cold taken branch, then fetch sees the new entry
    step(32'h0, 1, 1, 32'h100, 1, 1, 32'h200, 0, 32'h104);
    step(32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

    // Counter walks down and saturates at 00
    repeat (4) resolve(32'h100, 32'h100, 0, 32'h200);
    step(32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

    // Wrong-type: allocate 0x104, then a non-branch there predicted taken
    step(32'h0, 1, 1, 32'h104, 1, 1, 32'h500, 0, 32'h108);
    step(32'h104, 1, 1, 32'h104, 0, 0, 32'h0, 1, 32'h500);
    step(32'h104, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

    // Stall: mispredicted branch held four cycles then released
    repeat (4) step(32'h0, 1, 0, 32'h108, 1, 1, 32'h600, 0, 32'h10c);
    step(32'h108, 1, 1, 32'h108, 1, 1, 32'h600, 0, 32'h10c);
    step(32'h108, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

    // Target change on a hitting entry
    resolve(32'h100, 32'h100, 1, 32'h200);
    resolve(32'h100, 32'h100, 1, 32'h200);
    step(32'h100, 1, 1, 32'h100, 1, 1, 32'h300, 1, 32'h200);
    step(32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

    // mem_valid=0 masks everything
    step(32'h100, 0, 1, 32'h100, 1, 1, 32'h900, 1, 32'h0);

    // Randomized traffic over two aliasing PC regions
    for (int n = 0; n < 1500; n++) begin
      pc  = (($urandom_range(0, 1) == 0) ? 32'h100 : 32'h1100) + 32'(4 * $urandom_range(0, 7));
      fpc = (($urandom_range(0, 1) == 0) ? 32'h100 : 32'h1100) + 32'(4 * $urandom_range(0, 7));
      tgt = 32'h2000 + 32'(4 * $urandom_range(0, 3));
      model_predict(pc, p, pt);
      if ($urandom_range(0, 3) == 0) begin
        p  = 1'($urandom_range(0, 1));
        pt = tgt;
      end
      step(fpc, ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0), pc,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt, p, pt);
    end

    // Drive mispredict count into saturation
    for (int n = 0; n < 65540; n++) step(32'h7000, 1, 1, 32'h7000, 0, 0, 32'h0, 1, 32'h7010);

    // Asynchronous reset mid-run
    RST = 1'b1;
    step(32'h40, 1, 1, 32'h100, 1, 1, 32'h900, 0, 32'h104);
    RST = 1'b0;
    step(32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

    @(negedge CLK); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
